// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of a word-organised on-chip SRAM. The slave
// inserts a fixed number of wait states on every OKAY data phase. It supports
// byte, halfword and word writes with little-endian lane selection. Illegal
// transfers get the two-cycle ERROR response and never reach the array.
//
// Ports
//   HCLK       bus clock, every flop on the rising edge
//   HRESET     synchronous, active-high reset (memory contents are kept)
//   HSEL       slave select from the address decoder
//   HADDR      transfer address; word index = HADDR[AddresseWidth-1:2]
//   HTRANS     0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   HWRITE     1 write, 0 read
//   HSIZE      0 byte, 1 halfword, 2 word; anything else is illegal
//   HWDATA     write data, sampled on the edge that ends the data phase
//   HREADY     bus-level ready coming back from the response mux
//   HRDATA     read data (zero outside a read data phase)
//   HRESP      0 OKAY, 1 ERROR
//   HREADYOUT  this slave's ready
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no data phase in progress, ready
//   ST_WAIT  | OKAY data phase, HREADYOUT low while cnt_q runs down
//   ST_LAST  | final OKAY data cycle: read data out / write commits
//   ST_ERR1  | first ERROR cycle, HREADYOUT low
//   ST_ERR2  | second ERROR cycle, HREADYOUT high, next address sampled
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int AddresseWidth = 32,
  parameter int DataWidth     = 32,
  parameter int Depth         = 256,
  parameter int WaitStates    = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [AddresseWidth-1:0] HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [DataWidth-1:0]     HWDATA,
  input  logic                     HREADY,
  output logic [DataWidth-1:0]     HRDATA,
  output logic                     HRESP,
  output logic                     HREADYOUT
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  // Word-index limit at the width of the HADDR word-index field, so the
  // range check covers every upper address bit, not only the bits we store.
  localparam logic [AddresseWidth-3:0] DepthLim = (AddresseWidth-2)'(Depth);
  localparam logic [3:0]               WaitInit = 4'(WaitStates);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic                 cap;
  logic                 accept;
  logic                 illegal;
  logic                 commit;
  logic [3:0]           be;
  logic [DataWidth-1:0] mem [Depth];

  // HTRANS[0] only separates NONSEQ from SEQ (and IDLE from BUSY), which
  // makes no difference to a single-slot SRAM.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign accept = HSEL & HREADY & HTRANS[1];

  assign illegal = (HADDR[AddresseWidth-1:2] >= DepthLim)
                 | (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // ---------------------------------------------------------------------
  // Next-state logic. Address inputs are only looked at in the states
  // where the bus is ready (IDLE, LAST, ERR2); in WAIT/ERR1 HREADY is low
  // system-wide, so any address seen there is not a real address phase.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (accept) begin
          cap = 1'b1;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WaitStates > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WaitInit;
          end else begin
            state_d = ST_LAST;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_LAST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        idx_q   <= HADDR[IdxW+1:2];
        lane_q  <= HADDR[1:0];
        // Only legal sizes (0..2) ever reach LAST, so two bits suffice.
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write lane enables from the captured size/offset (little-endian).
  // The data path is four byte lanes wide.
  // ---------------------------------------------------------------------
  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'd0:    be[lane_q] = 1'b1;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A write lands on the edge that ends LAST. A reset on that same edge
  // drops it.
  assign commit = (state_q == ST_LAST) & write_q & ~HRESET;

  // The array has no reset: contents survive HRESET.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response outputs are decoded from registered state only. Read data comes
  // straight from the array at the captured index. A write committed on the
  // edge before is therefore visible at once, and read-after-write needs no
  // forwarding.
  // ---------------------------------------------------------------------
  assign HREADYOUT = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
  assign HRESP     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
  assign HRDATA    = ((state_q == ST_LAST) & ~write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// The reference model is a queue of expected data-phase cycles. Each accepted
// transfer appends its whole response: WS wait cycles plus one final cycle,
// or two ERROR cycles. Every clock pops one cycle, and an empty queue means
// idle. The bench acts as the master: it holds each address phase until
// HREADY is high, and it drives HREADY the way the response mux would.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int WS    = 1;
  localparam int DEPTH = 256;

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL   = 1'b0;
  logic [31:0] HADDR  = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE  = 3'd2;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT;

  ahb_sram_slave #(
    .AddresseWidth(32),
    .DataWidth    (32),
    .Depth        (DEPTH),
    .WaitStates   (WS)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .HREADYOUT(HREADYOUT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          rdy;
    bit          resp;
    logic [31:0] rdata;
    bit          commit;
    bit          is_rd;
    int          idx;
    bit [3:0]    be;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mmem [DEPTH];
  int          compared   = 0;
  int          mismatched = 0;
  bit          chk_en     = 1'b0;
  bit          rand_ready = 1'b0;
  logic [31:0] last_rd    = '0;
  int          err_cycles = 0;

  // Expected response of a transfer accepted on this edge.
  function automatic void push_phase();
    ent_t e;
    int   idx;
    int   lo;
    int   nb;
    bit   bad;
    idx = int'(HADDR[31:2]);
    lo  = int'(HADDR[1:0]);
    bad = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
          (HSIZE == 3'd2 && lo != 0) || (idx >= DEPTH);
    e.rdy = 1'b0; e.resp = 1'b0; e.rdata = '0; e.commit = 1'b0;
    e.is_rd = 1'b0; e.idx = 0; e.be = 4'b0000;
    if (bad) begin
      e.resp = 1'b1;
      mq.push_back(e);
      e.rdy = 1'b1;
      mq.push_back(e);
    end else begin
      for (int w = 0; w < WS; w++) mq.push_back(e);
      nb    = 1 << HSIZE;
      e.rdy = 1'b1;
      e.idx = idx;
      for (int b = 0; b < 4; b++) e.be[b] = (b >= lo && b < lo + nb);
      if (HWRITE) e.commit = 1'b1;
      else begin
        e.is_rd = 1'b1;
        e.rdata = mmem[idx];
      end
      mq.push_back(e);
    end
  endfunction

  // Model: advance one cycle on each rising edge.
  initial forever begin
    @(posedge HCLK);
    if (HRESET) begin
      mq.delete();
      chk_en = 1'b1;
    end else begin
      bit   open;
      ent_t e;
      open = 1'b1;
      if (mq.size() != 0) begin
        e    = mq.pop_front();
        open = e.rdy;
        if (e.resp) err_cycles++;
        if (e.commit)
          for (int b = 0; b < 4; b++)
            if (e.be[b]) mmem[e.idx][8*b +: 8] = HWDATA[8*b +: 8];
        if (e.is_rd) last_rd = e.rdata;
      end
      if (open && HSEL && HREADY && HTRANS[1]) push_phase();
    end
  end

  // Compare: DUT outputs against the model on every cycle, mid-cycle.
  initial forever begin
    @(negedge HCLK);
    if (chk_en) begin
      logic        er;
      logic        ep;
      logic [31:0] ed;
      er = 1'b1; ep = 1'b0; ed = '0;
      if (mq.size() != 0) begin
        er = mq[0].rdy; ep = mq[0].resp; ed = mq[0].rdata;
      end
      compared++;
      if (HREADYOUT !== er || HRESP !== ep || HRDATA !== ed) begin
        mismatched++;
        $display("FAIL bus_outputs t=%0t: got rdy=%0b resp=%0b rdata=%h, want rdy=%0b resp=%0b rdata=%h",
                 $time, HREADYOUT, HRESP, HRDATA, er, ep, ed);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    if (mq.size() != 0) HREADY = mq[0].rdy;
    else HREADY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // One address phase, held until HREADY is high. Its write data is driven
  // for the data phase that follows.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic rdy_seen;
    int   n;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
    n = 0;
    do begin
      rdy_seen = HREADY;
      step();
      n++;
    end while (!rdy_seen && n < 64);
    if (!rdy_seen) begin
      compared++;
      mismatched++;
      $display("FAIL addr_phase_timeout: got no HREADY in %0d cycles, want HREADY=1", n);
    end
    HWDATA = wr ? wdata : $urandom();
  endtask

  task automatic wait_idle();
    int n;
    issue(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    n = 0;
    while (mq.size() != 0 && n < 32) begin
      step();
      n++;
    end
    if (mq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: got %0d cycles still pending, want 0", mq.size());
    end
  endtask

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

  initial begin
    int e0;
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;

    // Fill the array so every later read has a known expected value.
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'(i * 4), $urandom());
    wait_idle();

    // Pipelined read-after-write with one wait state.
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h04, 32'h0);
    wait_idle();
    pin("raw_read_0x04", last_rd, 32'hDEADBEEF);

    // Lane selection; unused lanes of HWDATA carry junk.
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h08, 32'h00000000);
    issue(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h0B, 32'hAA776655);
    issue(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h08, 32'h99991234);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h08, 32'h0);
    wait_idle();
    pin("lanes_0x08", last_rd, 32'hAA001234);

    // ERROR responses, then a legal read pipelined in ERR2.
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h00, 32'h01020304);
    wait_idle();
    e0 = err_cycles;
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h02, 32'h0);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h400, 32'h0);
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h400, 32'h55555555);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
    wait_idle();
    pin("err_cycle_count", 32'(err_cycles - e0), 32'd6);
    pin("after_err_read_0x00", last_rd, 32'h01020304);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h02, 32'h0);
    wait_idle();

    // Reset in the middle of a write's wait state: that write is dropped.
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D);
    wait_idle();
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'h12345678);
    HSEL = 1'b0; HTRANS = T_IDLE; HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;
    @(negedge HCLK);
    pin("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    pin("rst_hresp", {31'b0, HRESP}, 32'd0);
    pin("rst_hrdata", HRDATA, 32'h0);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    wait_idle();
    pin("rst_no_commit_0x10", last_rd, 32'hCAFEF00D);

    // Deselected and BUSY transfers do nothing.
    issue(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h0C, 32'h0BADC0DE);
    issue(1'b0, T_NSEQ, 1'b1, 3'd2, 32'h0C, 32'hFFFFFFFF);
    issue(1'b1, T_BUSY, 1'b1, 3'd2, 32'h0C, 32'hEEEEEEEE);
    issue(1'b1, T_IDLE, 1'b1, 3'd2, 32'h0C, 32'hDDDDDDDD);
    issue(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h0C, 32'h0);
    wait_idle();
    pin("deselect_busy_0x0C", last_rd, 32'h0BADC0DE);

    // Random traffic: mixed sizes/offsets, stalls from other slaves, resets.
    rand_ready = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      if ($urandom_range(0, 199) == 0) begin
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
      end
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? ($urandom() & 32'h00000FFF) : ($urandom() & 32'h000003FF);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), sz, a, $urandom());
    end
    rand_ready = 1'b0;
    wait_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: got run still active at %0t, want completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
